// File: rtl/seg_scan_capture.sv
// Rebuilds the 4-digit hex value shown on a multiplexed seven-segment scan (an/seg, active-low).
// Optional stall watchdog enabled by defining SEG_SCAN_TIMEOUT_EN.
module seg_scan_capture #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        frame_pulse,
    output logic [3:0]  digit_valid,
    output logic        err_glyph,
    output logic        err_an,
    output logic        scan_stall
);

    localparam int CW = $clog2(SETTLE + 1);

    logic [3:0]    r_an_s1, r_an_s2, r_an_prev;
    logic [6:0]    r_seg_s1, r_seg_s2, r_seg_prev;
    logic [CW-1:0] r_stable_cnt;
    logic          r_armed;
    logic [15:0]   r_shadow;
    logic [15:0]   r_value;
    logic [3:0]    r_digit_valid;
    logic          r_frame_valid;
    logic          r_frame_pulse;
    logic          r_frame_pending;
    logic          r_err_glyph;
    logic          r_err_an;

    logic          w_same;
    logic          w_capture;
    logic [3:0]    w_sel;
    logic          w_blank;
    logic          w_one_hot;
    logic          w_glyph_ok;
    logic [3:0]    w_nibble;
    logic          w_write;
    logic [3:0]    w_dv_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an_s1  <= 4'h0;
            r_an_s2  <= 4'h0;
            r_seg_s1 <= 7'h00;
            r_seg_s2 <= 7'h00;
        end else begin
            r_an_s1  <= an;
            r_an_s2  <= r_an_s1;
            r_seg_s1 <= seg;
            r_seg_s2 <= r_seg_s1;
        end
    end

    // The decoded pair is the previous-cycle copy, i.e. the value whose stability was counted.
    assign w_same    = ({r_an_s2, r_seg_s2} == {r_an_prev, r_seg_prev});
    assign w_capture = r_armed && (r_stable_cnt == CW'(SETTLE));
    assign w_sel     = ~r_an_prev;
    assign w_blank   = (r_an_prev == 4'hF);
    assign w_one_hot = !w_blank && ((w_sel & (w_sel - 4'd1)) == 4'd0);
    assign w_write   = w_capture && w_one_hot && w_glyph_ok;
    assign w_dv_next = r_digit_valid | w_sel;

    always_comb begin
        w_glyph_ok = 1'b1;
        w_nibble   = 4'h0;
        case (r_seg_prev)
            7'h01: w_nibble = 4'h0;
            7'h4F: w_nibble = 4'h1;
            7'h12: w_nibble = 4'h2;
            7'h06: w_nibble = 4'h3;
            7'h4C: w_nibble = 4'h4;
            7'h24: w_nibble = 4'h5;
            7'h20: w_nibble = 4'h6;
            7'h0F: w_nibble = 4'h7;
            7'h00: w_nibble = 4'h8;
            7'h04: w_nibble = 4'h9;
            7'h08: w_nibble = 4'hA;
            7'h60: w_nibble = 4'hB;
            7'h31: w_nibble = 4'hC;
            7'h42: w_nibble = 4'hD;
            7'h30: w_nibble = 4'hE;
            7'h38: w_nibble = 4'hF;
            default: w_glyph_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an_prev    <= 4'h0;
            r_seg_prev   <= 7'h00;
            r_stable_cnt <= '0;
            r_armed      <= 1'b1;
        end else begin
            r_an_prev  <= r_an_s2;
            r_seg_prev <= r_seg_s2;
            if (!w_same) begin
                r_stable_cnt <= '0;
                r_armed      <= 1'b1;
            end else begin
                if (r_stable_cnt != CW'(SETTLE))
                    r_stable_cnt <= r_stable_cnt + 1'b1;
                if (w_capture)
                    r_armed <= 1'b0;
            end
        end
    end

    // Completion is deferred one cycle so value picks up the nibble written by the final capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow        <= 16'h0000;
            r_value         <= 16'h0000;
            r_digit_valid   <= 4'h0;
            r_frame_valid   <= 1'b0;
            r_frame_pulse   <= 1'b0;
            r_frame_pending <= 1'b0;
            r_err_glyph     <= 1'b0;
            r_err_an        <= 1'b0;
        end else begin
            r_frame_pulse <= 1'b0;
            r_err_glyph   <= w_capture && w_one_hot && !w_glyph_ok;
            r_err_an      <= w_capture && !w_blank && !w_one_hot;
            if (w_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_sel[i])
                        r_shadow[4*i +: 4] <= w_nibble;
                end
            end
            if (r_frame_pending) begin
                r_value         <= r_shadow;
                r_frame_pulse   <= 1'b1;
                r_frame_valid   <= 1'b1;
                r_digit_valid   <= 4'h0;
                r_frame_pending <= 1'b0;
            end else if (w_write) begin
                r_digit_valid   <= w_dv_next;
                r_frame_pending <= (w_dv_next == 4'hF);
            end
        end
    end

`ifdef SEG_SCAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_idle_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_idle_cnt <= '0;
        else if (w_write)
            r_idle_cnt <= '0;
        else if (r_idle_cnt != TW'(TIMEOUT))
            r_idle_cnt <= r_idle_cnt + 1'b1;
    end

    assign scan_stall = (r_idle_cnt == TW'(TIMEOUT));
`else
    assign scan_stall = 1'b0;
`endif

    assign value       = r_value;
    assign frame_valid = r_frame_valid;
    assign frame_pulse = r_frame_pulse;
    assign digit_valid = r_digit_valid;
    assign err_glyph   = r_err_glyph;
    assign err_an      = r_err_an;

endmodule
